result_pipeline: RTL and testbench

EX/MEM and MEM/WB pipeline register pair for the 64-bit RISC-V core. It produces the `EX_MEM_*` and `MEM_WB_*` sources consumed by the execute-stage forwarding unit and drives the data-memory request with a ready handshake and timeout. It also generates load-use stall and freeze controls for the front of the pipe.

---
 rtl/result_pipeline.sv | 166 ++++++++++++++++
 tb/tb_result_pipeline.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_pipeline.sv
// EX/MEM and MEM/WB pipeline registers with a data-memory handshake, timeout abort and stall/freeze controls.
// Optional macro RESULT_PIPE_LOAD_FWD_EN: MEM_WB_ALUResult carries wb_data so loads forward from MEM/WB.
`timescale 1ns/1ps
module result_pipeline #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [63:0] ex_alu_result,
  input  logic [63:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_mem_to_reg,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata,
  output logic [63:0] EX_MEM_ALUResult,
  output logic [4:0]  EX_MEM_RegisterRd,
  output logic        EX_MEM_RegWrite,
  output logic [63:0] MEM_WB_ALUResult,
  output logic [63:0] MEM_WB_mem_readData,
  output logic [4:0]  MEM_WB_RegisterRd,
  output logic        MEM_WB_RegWrite,
  output logic [63:0] wb_data,
  output logic        load_use_stall,
  output logic        mem_freeze,
  output logic        mem_error
);
  localparam logic RUN  = 1'b0;
  localparam logic WAIT = 1'b1;

  logic        exm_valid_reg;
  logic [63:0] exm_alu_reg;
  logic [63:0] exm_store_reg;
  logic [4:0]  exm_rd_reg;
  logic        exm_reg_write_reg;
  logic        exm_mem_read_reg;
  logic        exm_mem_write_reg;
  logic        exm_mem_to_reg_reg;

  logic [63:0] mwb_alu_reg;
  logic [63:0] mwb_rdata_reg;
  logic [4:0]  mwb_rd_reg;
  logic        mwb_reg_write_reg;
  logic        mwb_mem_to_reg_reg;

  logic        state_reg, state_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic        timeout;
  logic [9:0]  id_rs_flat;
  logic [1:0]  rs_hit;

  assign mem_req   = exm_valid_reg & (exm_mem_read_reg | exm_mem_write_reg);
  assign mem_we    = exm_mem_write_reg;
  assign mem_addr  = exm_alu_reg;
  assign mem_wdata = exm_store_reg;

  // The RUN cycle that issued the request is the first wait cycle, so WAIT's count lags by one.
  assign timeout    = mem_req & (state_reg == WAIT) & ~mem_ready &
                      (wait_cnt_reg == 8'(MEM_TIMEOUT - 2));
  assign mem_freeze = mem_req & ~mem_ready & ~timeout;
  assign mem_error  = timeout;

  assign id_rs_flat = {id_rs2, id_rs1};
  for (genvar gi = 0; gi < 2; gi++) begin : g_rs_hit
    assign rs_hit[gi] = (id_rs_flat[gi*5 +: 5] == ex_rd);
  end

  assign load_use_stall = reset & ex_valid & ex_mem_read & ex_reg_write &
                          (ex_rd != 5'd0) & (|rs_hit) & ~mem_freeze;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_next    = WAIT;
          wait_cnt_next = 8'd0;
        end
      end
      default: begin
        if (mem_ready || timeout) state_next = RUN;
        else                      wait_cnt_next = wait_cnt_reg + 8'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= RUN;
      wait_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exm_valid_reg      <= 1'b0;
      exm_alu_reg        <= '0;
      exm_store_reg      <= '0;
      exm_rd_reg         <= '0;
      exm_reg_write_reg  <= 1'b0;
      exm_mem_read_reg   <= 1'b0;
      exm_mem_write_reg  <= 1'b0;
      exm_mem_to_reg_reg <= 1'b0;
    end else if (!mem_freeze) begin
      exm_valid_reg      <= ex_valid;
      exm_alu_reg        <= ex_valid ? ex_alu_result : '0;
      exm_store_reg      <= ex_valid ? ex_store_data : '0;
      exm_rd_reg         <= ex_valid ? ex_rd : '0;
      exm_reg_write_reg  <= ex_valid & ex_reg_write;
      exm_mem_read_reg   <= ex_valid & ex_mem_read;
      exm_mem_write_reg  <= ex_valid & ex_mem_write;
      exm_mem_to_reg_reg <= ex_valid & ex_mem_to_reg;
    end
  end

  // A frozen cycle retires nothing: MEM/WB takes an all-zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mwb_alu_reg        <= '0;
      mwb_rdata_reg      <= '0;
      mwb_rd_reg         <= '0;
      mwb_reg_write_reg  <= 1'b0;
      mwb_mem_to_reg_reg <= 1'b0;
    end else if (mem_freeze) begin
      mwb_alu_reg        <= '0;
      mwb_rdata_reg      <= '0;
      mwb_rd_reg         <= '0;
      mwb_reg_write_reg  <= 1'b0;
      mwb_mem_to_reg_reg <= 1'b0;
    end else begin
      mwb_alu_reg        <= exm_alu_reg;
      mwb_rdata_reg      <= (exm_valid_reg & exm_mem_read_reg & mem_ready) ? mem_rdata : '0;
      mwb_rd_reg         <= exm_rd_reg;
      mwb_reg_write_reg  <= exm_valid_reg & exm_reg_write_reg & ~timeout;
      mwb_mem_to_reg_reg <= exm_valid_reg & exm_mem_to_reg_reg;
    end
  end

  assign EX_MEM_ALUResult    = exm_alu_reg;
  assign EX_MEM_RegisterRd   = exm_rd_reg;
  assign EX_MEM_RegWrite     = exm_valid_reg & exm_reg_write_reg;
  assign MEM_WB_mem_readData = mwb_rdata_reg;
  assign MEM_WB_RegisterRd   = mwb_rd_reg;
  assign MEM_WB_RegWrite     = mwb_reg_write_reg;
  assign wb_data             = mwb_mem_to_reg_reg ? mwb_rdata_reg : mwb_alu_reg;

`ifdef RESULT_PIPE_LOAD_FWD_EN
  assign MEM_WB_ALUResult = wb_data;
`else
  assign MEM_WB_ALUResult = mwb_alu_reg;
`endif

endmodule

// File: tb/tb_result_pipeline.sv
// Directed bench for result_pipeline: per-cycle comparison against a transaction-level model plus literal checks.
`timescale 1ns/1ps
module tb_result_pipeline;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [63:0] ex_alu_result, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [4:0]  id_rs1, id_rs2;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic [63:0] EX_MEM_ALUResult;
  logic [4:0]  EX_MEM_RegisterRd;
  logic        EX_MEM_RegWrite;
  logic [63:0] MEM_WB_ALUResult, MEM_WB_mem_readData;
  logic [4:0]  MEM_WB_RegisterRd;
  logic        MEM_WB_RegWrite;
  logic [63:0] wb_data;
  logic        load_use_stall, mem_freeze, mem_error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  result_pipeline #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .EX_MEM_ALUResult(EX_MEM_ALUResult), .EX_MEM_RegisterRd(EX_MEM_RegisterRd),
    .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .MEM_WB_ALUResult(MEM_WB_ALUResult), .MEM_WB_mem_readData(MEM_WB_mem_readData),
    .MEM_WB_RegisterRd(MEM_WB_RegisterRd), .MEM_WB_RegWrite(MEM_WB_RegWrite),
    .wb_data(wb_data), .load_use_stall(load_use_stall),
    .mem_freeze(mem_freeze), .mem_error(mem_error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: instruction sitting in EX/MEM, instruction retired to MEM/WB, cycles the access has waited.
  typedef struct packed {
    logic        v;
    logic [63:0] alu;
    logic [63:0] sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, m2r;
  } exm_t;
  typedef struct packed {
    logic [63:0] alu;
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        rw, m2r;
  } mwb_t;

  exm_t cur_e = '0, nxt_e = '0;
  mwb_t cur_m = '0, nxt_m = '0;
  int   cur_w = 0,  nxt_w = 0;

  always @(posedge clk) begin
    cur_e <= nxt_e;
    cur_m <= nxt_m;
    cur_w <= nxt_w;
  end

  always @(negedge clk) begin : compare
    exm_t e;
    mwb_t m;
    int w;
    logic req, to, frz, lus;
    logic [63:0] wbd, mwb_alu_exp;
    e = reset ? cur_e : '0;
    m = reset ? cur_m : '0;
    w = reset ? cur_w : 0;
    req = e.v & (e.mr | e.mw);
    to  = req & !mem_ready & (w == TMO - 1);
    frz = req & !mem_ready & !to;
    lus = reset & ex_valid & ex_mem_read & ex_reg_write & (ex_rd != 5'd0) &
          ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & !frz;
    wbd = m.m2r ? m.rdata : m.alu;
`ifdef RESULT_PIPE_LOAD_FWD_EN
    mwb_alu_exp = wbd;
`else
    mwb_alu_exp = m.alu;
`endif
    check("mem_req",        64'(mem_req),             64'(req));
    check("mem_we",         64'(mem_we),              64'(e.mw));
    check("mem_addr",       mem_addr,                 e.alu);
    check("mem_wdata",      mem_wdata,                e.sd);
    check("ex_mem_alu",     EX_MEM_ALUResult,         e.alu);
    check("ex_mem_rd",      64'(EX_MEM_RegisterRd),   64'(e.rd));
    check("ex_mem_rw",      64'(EX_MEM_RegWrite),     64'(e.v & e.rw));
    check("mem_wb_alu",     MEM_WB_ALUResult,         mwb_alu_exp);
    check("mem_wb_rdata",   MEM_WB_mem_readData,      m.rdata);
    check("mem_wb_rd",      64'(MEM_WB_RegisterRd),   64'(m.rd));
    check("mem_wb_rw",      64'(MEM_WB_RegWrite),     64'(m.rw));
    check("wb_data",        wb_data,                  wbd);
    check("load_use_stall", 64'(load_use_stall),      64'(lus));
    check("mem_freeze",     64'(mem_freeze),          64'(frz));
    check("mem_error",      64'(mem_error),           64'(to));
    if (!reset) begin
      nxt_e = '0; nxt_m = '0; nxt_w = 0;
    end else if (frz) begin
      nxt_e = e; nxt_m = '0; nxt_w = w + 1;
    end else begin
      nxt_e = '0;
      if (ex_valid) begin
        nxt_e.v = 1'b1; nxt_e.alu = ex_alu_result; nxt_e.sd = ex_store_data; nxt_e.rd = ex_rd;
        nxt_e.rw = ex_reg_write; nxt_e.mr = ex_mem_read; nxt_e.mw = ex_mem_write;
        nxt_e.m2r = ex_mem_to_reg;
      end
      nxt_m.alu   = e.alu;
      nxt_m.rdata = (e.v & e.mr & mem_ready) ? mem_rdata : 64'd0;
      nxt_m.rd    = e.rd;
      nxt_m.rw    = e.v & e.rw & !to;
      nxt_m.m2r   = e.v & e.m2r;
      nxt_w = 0;
    end
  end

  task automatic drive(input logic v, input logic [63:0] alu, input logic [63:0] sd,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic m2r);
    ex_valid = v; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_mem_to_reg = m2r;
  endtask

  task automatic bubble();
    drive(1'b0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [63:0] fwd_exp;
    reset = 1'b0;
    bubble();
    id_rs1 = 5'd0; id_rs2 = 5'd0;
    mem_ready = 1'b0; mem_rdata = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_ex_mem_rw", 64'(EX_MEM_RegWrite), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    reset = 1'b1;

    // add x5 = 0x2A, then bubbles
    cyc();
    drive(1'b1, 64'h2A, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    bubble(); #1;
    check("t1_ex_mem_rd", 64'(EX_MEM_RegisterRd), 64'd5);
    check("t1_ex_mem_rw", 64'(EX_MEM_RegWrite), 64'd1);
    check("t1_ex_mem_alu", EX_MEM_ALUResult, 64'h2A);
    cyc();
    check("t1_mem_wb_rd", 64'(MEM_WB_RegisterRd), 64'd5);
    check("t1_mem_wb_rw", 64'(MEM_WB_RegWrite), 64'd1);
    check("t1_mem_wb_alu", MEM_WB_ALUResult, 64'h2A);
    check("t1_wb_data", wb_data, 64'h2A);

    // load-use detection
    cyc();
    drive(1'b1, 64'h100, 64'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    id_rs2 = 5'd6; #1;
    check("t2_lus_rs2", 64'(load_use_stall), 64'd1);
    id_rs2 = 5'd7; #1;
    check("t2_lus_nomatch", 64'(load_use_stall), 64'd0);
    id_rs1 = 5'd0;
    drive(1'b1, 64'h100, 64'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1); #1;
    check("t2_lus_x0", 64'(load_use_stall), 64'd0);
    bubble(); id_rs1 = 5'd0; id_rs2 = 5'd0;

    // ld x6 with three wait cycles; a dependent load waits in EX meanwhile
    cyc();
    drive(1'b1, 64'h200, 64'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    mem_ready = 1'b0;
    cyc();
    bubble(); #1;
    check("t3_req", 64'(mem_req), 64'd1);
    check("t3_addr", mem_addr, 64'h200);
    check("t3_freeze0", 64'(mem_freeze), 64'd1);
    cyc();
    drive(1'b1, 64'h300, 64'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    id_rs1 = 5'd9; #1;
    check("t3_freeze1", 64'(mem_freeze), 64'd1);
    check("t3_freeze_wins", 64'(load_use_stall), 64'd0);
    check("t3_mem_wb_rw_frozen", 64'(MEM_WB_RegWrite), 64'd0);
    cyc();
    check("t3_freeze2", 64'(mem_freeze), 64'd1);
    cyc();
    mem_ready = 1'b1; mem_rdata = 64'hDEAD; #1;
    check("t3_freeze3_released", 64'(mem_freeze), 64'd0);
    check("t3_lus_reeval", 64'(load_use_stall), 64'd1);
    cyc();
    bubble(); id_rs1 = 5'd0; mem_rdata = 64'hBEEF; #1;
    check("t3_rdata", MEM_WB_mem_readData, 64'hDEAD);
    check("t3_wb_data", wb_data, 64'hDEAD);
    check("t3_mem_wb_rd", 64'(MEM_WB_RegisterRd), 64'd6);
    check("t3_mem_wb_rw", 64'(MEM_WB_RegWrite), 64'd1);
    check("t3_zero_wait_nofreeze", 64'(mem_freeze), 64'd0);
    cyc();
    mem_ready = 1'b0; #1;
    check("t3_rdata2", MEM_WB_mem_readData, 64'hBEEF);
    check("t3_mem_wb_rd2", 64'(MEM_WB_RegisterRd), 64'd9);

    // sd with mem_ready never asserted: timeout after TMO cycles
    drive(1'b1, 64'h400, 64'h55, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc();
    bubble(); #1;
    check("t4_we", 64'(mem_we), 64'd1);
    check("t4_wdata", mem_wdata, 64'h55);
    for (int k = 0; k < TMO - 1; k++) begin
      check("t4_freeze", 64'(mem_freeze), 64'd1);
      check("t4_no_error", 64'(mem_error), 64'd0);
      cyc();
    end
    check("t4_error", 64'(mem_error), 64'd1);
    check("t4_freeze_low", 64'(mem_freeze), 64'd0);
    cyc();
    check("t4_error_pulse", 64'(mem_error), 64'd0);
    check("t4_req_done", 64'(mem_req), 64'd0);
    check("t4_mem_wb_rw", 64'(MEM_WB_RegWrite), 64'd0);

    // ld x8 timing out: its RegWrite must not retire
    drive(1'b1, 64'h480, 64'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc();
    bubble();
    repeat (TMO - 1) cyc();
    check("t4b_error", 64'(mem_error), 64'd1);
    cyc();
    check("t4b_mem_wb_rw", 64'(MEM_WB_RegWrite), 64'd0);

    // reset asserted in the middle of a wait
    drive(1'b1, 64'h500, 64'd0, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc();
    bubble(); #1;
    check("t5_freeze_before", 64'(mem_freeze), 64'd1);
    cyc();
    reset = 1'b0; #1;
    check("t5_req", 64'(mem_req), 64'd0);
    check("t5_freeze", 64'(mem_freeze), 64'd0);
    check("t5_error", 64'(mem_error), 64'd0);
    check("t5_ex_mem_alu", EX_MEM_ALUResult, 64'd0);
    check("t5_ex_mem_rw", 64'(EX_MEM_RegWrite), 64'd0);
    check("t5_wb_data", wb_data, 64'd0);
    cyc();
    reset = 1'b1;
    cyc();
    check("t5_error_after", 64'(mem_error), 64'd0);
    check("t5_req_after", 64'(mem_req), 64'd0);

    // ld x7 of 0x77, zero wait; mem_ready high beforehand is ignored
    mem_ready = 1'b1; mem_rdata = 64'h77;
    drive(1'b1, 64'h1000, 64'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc();
    bubble(); #1;
    check("t6_nofreeze", 64'(mem_freeze), 64'd0);
    cyc();
    mem_ready = 1'b0;
`ifdef RESULT_PIPE_LOAD_FWD_EN
    fwd_exp = 64'h77;
`else
    fwd_exp = 64'h1000;
`endif
    check("t6_mem_wb_alu", MEM_WB_ALUResult, fwd_exp);
    check("t6_wb_data", wb_data, 64'h77);
    check("t6_rdata", MEM_WB_mem_readData, 64'h77);
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
